video_timing_pal: RTL and testbench

Parametrised raster timing generator and palette output stage for the video subsystem. Divides the system clock into a pixel enable, runs programmable horizontal/vertical counters, and raises a vblank flag and NMI toward the CPU. Holds a host-writable 32-entry palette RAM and converts renderer palette indices to 24-bit RGB through a registered two-stage pipeline.

---
 rtl/video_timing_pal_if.sv | 30 +++
 rtl/video_timing_pal.sv | 113 +++++++++++
 tb/tb_video_timing_pal.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_pal_if.sv
// video_timing_pal_if: raster, host register and RGB signals of the video timing/palette block
interface video_timing_pal_if #(parameter int CW = 9);
    logic          pix_ce;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          active;
    logic [4:0]    pix_index;
    logic [2:0]    host_addr;
    logic          host_wren;
    logic          host_rden;
    logic [7:0]    host_wdata;
    logic [7:0]    host_rdata;
    logic          host_nmi;
    logic          vid_hsync;
    logic          vid_vsync;
    logic          vid_blank;
    logic [7:0]    vid_red;
    logic [7:0]    vid_green;
    logic [7:0]    vid_blue;
    modport master (
        input  pix_ce, pix_x, pix_y, active, host_rdata, host_nmi,
               vid_hsync, vid_vsync, vid_blank, vid_red, vid_green, vid_blue,
        output pix_index, host_addr, host_wren, host_rden, host_wdata
    );
    modport slave (
        output pix_ce, pix_x, pix_y, active, host_rdata, host_nmi,
               vid_hsync, vid_vsync, vid_blank, vid_red, vid_green, vid_blue,
        input  pix_index, host_addr, host_wren, host_rden, host_wdata
    );
endinterface

// File: rtl/video_timing_pal.sv
// video_timing_pal: pixel divider, raster counters, vblank/NMI host registers and palette-to-RGB pipeline
module video_timing_pal #(
    parameter int CLK_DIV      = 4,
    parameter int CW           = 9,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 275,
    parameter int H_SYNC_END   = 300,
    parameter int H_TOTAL      = 341,
    parameter int V_ACTIVE     = 240,
    parameter int V_SYNC_START = 242,
    parameter int V_SYNC_END   = 244,
    parameter int V_TOTAL      = 262
) (
    input logic clk,
    input logic rst,
    video_timing_pal_if.slave bus
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [23:0] ROM [64] = '{
        24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
        24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
        24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
        24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
        24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
        24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
    };
    logic [DW-1:0] div;
    logic [CW-1:0] x, y;
    logic [7:0]    ctrl, ctrl_next, rdata;
    logic [4:0]    ptr;
    logic [5:0]    pal [32];
    logic [5:0]    pal_q;
    logic [23:0]   rgb;
    logic vblank, nmi, s1_blank, s1_hs, s1_vs, blank, hs, vs;
    logic pce, x_end, y_end, vis, in_hs, in_vs, rd, wr, status_rd, pdata_acc, vb_set, vb_clr, vb_next;
    // entries 0x10/0x14/0x18/0x1C share storage with 0x00/0x04/0x08/0x0C
    function automatic logic [4:0] mirror(input logic [4:0] a);
        return (a[4] && a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
    endfunction
    assign pce       = div == DW'(CLK_DIV - 1);
    assign x_end     = x == CW'(H_TOTAL - 1);
    assign y_end     = y == CW'(V_TOTAL - 1);
    assign vis       = x < CW'(H_ACTIVE) && y < CW'(V_ACTIVE);
    assign in_hs     = x >= CW'(H_SYNC_START) && x <= CW'(H_SYNC_END);
    assign in_vs     = y >= CW'(V_SYNC_START) && y <= CW'(V_SYNC_END);
    assign wr        = bus.host_wren;
    assign rd        = bus.host_rden && !bus.host_wren;
    assign status_rd = rd && bus.host_addr == 3'd2;
    assign pdata_acc = (wr || rd) && bus.host_addr == 3'd7;
    assign vb_set    = pce && x == '0 && y == CW'(V_ACTIVE + 1);
    assign vb_clr    = pce && x == '0 && y == CW'(V_TOTAL - 1);
    // a set event wins over a simultaneous STATUS read, which still returns the old flag
    assign vb_next   = vb_set || (vblank && !vb_clr && !status_rd);
    assign ctrl_next = (wr && bus.host_addr == 3'd0) ? bus.host_wdata : ctrl;
    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            x        <= '0;
            y        <= '0;
            vblank   <= 1'b0;
            ctrl     <= '0;
            ptr      <= '0;
            nmi      <= 1'b0;
            rdata    <= '0;
            s1_blank <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            blank    <= 1'b0;
            hs       <= 1'b1;
            vs       <= 1'b1;
            rgb      <= '0;
        end else begin
            div <= pce ? '0 : div + 1'b1;
            if (pce) begin
                x <= x_end ? '0 : x + 1'b1;
                if (x_end) y <= y_end ? '0 : y + 1'b1;
                s1_blank <= vis;
                s1_hs    <= ~in_hs;
                s1_vs    <= ~in_vs;
                blank    <= s1_blank;
                hs       <= s1_hs;
                vs       <= s1_vs;
                rgb      <= s1_blank ? ROM[pal_q] : '0;
            end
            vblank <= vb_next;
            ctrl   <= ctrl_next;
            nmi    <= vb_next && ctrl_next[7];
            if (wr && bus.host_addr == 3'd6) ptr <= bus.host_wdata[4:0];
            else if (pdata_acc) ptr <= ptr + 1'b1;
            if (rd) rdata <= status_rd ? {vblank, 7'b0} :
                             bus.host_addr == 3'd7 ? {2'b00, pal[mirror(ptr)]} : 8'h00;
        end
    end
    // palette storage survives reset; the pixel read sees the value before a same-cycle host write
    always_ff @(posedge clk) begin
        if (!rst && wr && bus.host_addr == 3'd7) pal[mirror(ptr)] <= bus.host_wdata[5:0];
        if (pce) pal_q <= pal[mirror(bus.pix_index)];
    end
    assign bus.pix_ce     = pce;
    assign bus.pix_x      = x;
    assign bus.pix_y      = y;
    assign bus.active     = vis;
    assign bus.host_rdata = rdata;
    assign bus.host_nmi   = nmi;
    assign bus.vid_hsync  = hs;
    assign bus.vid_vsync  = vs;
    assign bus.vid_blank  = blank;
    assign bus.vid_red    = rgb[23:16];
    assign bus.vid_green  = rgb[15:8];
    assign bus.vid_blue   = rgb[7:0];
endmodule

// File: tb/tb_video_timing_pal.sv
// tb_video_timing_pal: random host/pixel traffic against a position-arithmetic reference model,
// expectations queued per clock and compared by an independent monitor on the falling edge.
module tb_video_timing_pal;
    localparam int D = 4, CW = 9, HA = 16, HSS = 19, HSE = 22, HT = 26;
    localparam int VA = 10, VSS = 11, VSE = 12, VT = 15;
    localparam int FRAME = D * HT * VT;
    localparam logic [23:0] ROM [64] = '{
        24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
        24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
        24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
        24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
        24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
        24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
    };
    typedef struct { int x; int y; bit pce; bit active; bit nmi; logic [7:0] rdata; } st_t;
    typedef struct { bit known; bit blank; bit hs; bit vs; logic [23:0] rgb; } vid_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, fails = 0;
    st_t sq[$];
    vid_t vq[$], hist[$];
    vid_t vout;
    int n = 0, ptr = 0;
    bit started = 0, vb = 0, nmi = 0, rand_idx = 1;
    logic [7:0] ctrl = 8'h00, rdata = 8'h00;
    logic [5:0] pal [32];
    bit palv [32];
    video_timing_pal_if #(.CW(CW)) bus ();
    video_timing_pal #(
        .CLK_DIV(D), .CW(CW), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
    ) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic int mir(input int a);
        return (a >= 16 && a % 4 == 0) ? a - 16 : a;
    endfunction
    function automatic int px(input int c);
        return (c / D) % HT;
    endfunction
    function automatic int py(input int c);
        return (c / D / HT) % VT;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // reference model: position is pure arithmetic on clocks since reset
    always @(posedge clk) begin : model
        bit pce, srd, set, clr;
        int x0, y0, x1, y1, pi;
        vid_t v;
        if (rst) begin
            n = 0; vb = 0; nmi = 0; ctrl = 8'h00; rdata = 8'h00; ptr = 0; started = 1;
            hist.delete();
            vout = '{1, 0, 1, 1, 24'h0};
        end else if (started) begin
            pce = n % D == D - 1;
            x0 = px(n);
            y0 = py(n);
            if (pce) begin
                pi = mir(int'(bus.pix_index));
                v.blank = x0 < HA && y0 < VA;
                v.hs = !(x0 >= HSS && x0 <= HSE);
                v.vs = !(y0 >= VSS && y0 <= VSE);
                v.known = !v.blank || palv[pi];
                v.rgb = v.blank ? ROM[pal[pi]] : 24'h0;
                if (hist.size() > 0) vout = hist.pop_front();
                hist.push_back(v);
            end
            n++;
            x1 = px(n);
            y1 = py(n);
            set = pce && x1 == 1 && y1 == VA + 1;
            clr = pce && x1 == 1 && y1 == VT - 1;
            srd = 0;
            if (bus.host_wren) begin
                if (bus.host_addr == 3'd0) ctrl = bus.host_wdata;
                else if (bus.host_addr == 3'd6) ptr = int'(bus.host_wdata) % 32;
                else if (bus.host_addr == 3'd7) begin
                    pal[mir(ptr)] = bus.host_wdata[5:0];
                    palv[mir(ptr)] = 1;
                    ptr = (ptr + 1) % 32;
                end
            end else if (bus.host_rden) begin
                if (bus.host_addr == 3'd2) begin
                    rdata = {vb, 7'b0};
                    srd = 1;
                end else if (bus.host_addr == 3'd7) begin
                    rdata = {2'b00, pal[mir(ptr)]};
                    ptr = (ptr + 1) % 32;
                end else rdata = 8'h00;
            end
            vb = set || (vb && !clr && !srd);
            nmi = vb && ctrl[7];
        end
        if (started) begin
            sq.push_back('{px(n), py(n), n % D == D - 1, px(n) < HA && py(n) < VA, nmi, rdata});
            vq.push_back(vout);
        end
    end
    always @(negedge clk) begin : monitor
        st_t e;
        vid_t w;
        while (sq.size() > 0 && vq.size() > 0) begin
            e = sq.pop_front();
            w = vq.pop_front();
            chk("pix_x", 32'(bus.pix_x), e.x);
            chk("pix_y", 32'(bus.pix_y), e.y);
            chk("pix_ce", 32'(bus.pix_ce), 32'(e.pce));
            chk("active", 32'(bus.active), 32'(e.active));
            chk("host_nmi", 32'(bus.host_nmi), 32'(e.nmi));
            chk("host_rdata", 32'(bus.host_rdata), 32'(e.rdata));
            chk("vid_blank", 32'(bus.vid_blank), 32'(w.blank));
            chk("vid_hsync", 32'(bus.vid_hsync), 32'(w.hs));
            chk("vid_vsync", 32'(bus.vid_vsync), 32'(w.vs));
            if (w.known) chk("vid_rgb", 32'({bus.vid_red, bus.vid_green, bus.vid_blue}), 32'(w.rgb));
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_idx) bus.pix_index = 5'($urandom);
    endtask
    task automatic host(input logic [2:0] a, input bit w, input bit r, input logic [7:0] d);
        bus.host_addr = a;
        bus.host_wren = w;
        bus.host_rden = r;
        bus.host_wdata = d;
        cyc();
        bus.host_wren = 1'b0;
        bus.host_rden = 1'b0;
    endtask
    initial begin
        int k;
        bus.pix_index = '0; bus.host_addr = '0; bus.host_wren = 1'b0; bus.host_rden = 1'b0; bus.host_wdata = '0;
        repeat (3) cyc();
        chk("rst_x", 32'(bus.pix_x), 0);
        chk("rst_nmi", 32'(bus.host_nmi), 0);
        chk("rst_hsync", 32'(bus.vid_hsync), 1);
        chk("rst_blank", 32'(bus.vid_blank), 0);
        rst = 1'b0;
        host(3'd6, 1, 0, 8'h00);
        for (int i = 0; i < 32; i++) host(3'd7, 1, 0, 8'($urandom));
        host(3'd6, 1, 0, 8'h10);
        host(3'd7, 1, 0, 8'h2A);
        host(3'd6, 1, 0, 8'h00);
        host(3'd7, 0, 1, 8'h00);
        chk("pdata_mirror", 32'(bus.host_rdata), 32'h2A);
        host(3'd7, 0, 1, 8'h00);
        rand_idx = 0;
        bus.pix_index = 5'd0;
        repeat (3 * D) cyc();
        for (k = 0; k < 2 * FRAME && !bus.vid_blank; k++) cyc();
        chk("rgb_vis_seen", 32'(bus.vid_blank), 1);
        chk("rgb_entry_2a", 32'({bus.vid_red, bus.vid_green, bus.vid_blue}), 32'h5CE430);
        rand_idx = 1;
        host(3'd0, 1, 0, 8'h80);
        for (k = 0; k < 2 * FRAME && !bus.host_nmi; k++) cyc();
        chk("nmi_raised", 32'(bus.host_nmi), 1);
        host(3'd2, 0, 1, 8'h00);
        chk("status_set", 32'(bus.host_rdata), 32'h80);
        chk("nmi_dropped", 32'(bus.host_nmi), 0);
        host(3'd2, 0, 1, 8'h00);
        chk("status_cleared", 32'(bus.host_rdata), 32'h00);
        for (k = 0; k < 2 * FRAME; k++) begin
            if (n % D == D - 1 && px(n + 1) == 1 && py(n + 1) == VA + 1) break;
            cyc();
        end
        chk("set_cycle_found", 32'(k < 2 * FRAME), 1);
        host(3'd2, 0, 1, 8'h00);
        chk("status_race", 32'(bus.host_rdata), 32'h00);
        host(3'd2, 0, 1, 8'h00);
        chk("status_after_race", 32'(bus.host_rdata), 32'h80);
        repeat (6000) begin
            case ($urandom_range(0, 11))
                0: host(3'd0, 1, 0, 8'($urandom));
                1: host(3'd2, 0, 1, 8'h00);
                2: host(3'd6, 1, 0, 8'($urandom));
                3: host(3'd7, 1, 0, 8'($urandom));
                4: host(3'd7, 0, 1, 8'h00);
                5: host(3'd7, 1, 1, 8'($urandom));
                6: host(3'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
                default: cyc();
            endcase
        end
        host(3'd0, 1, 0, 8'h80);
        repeat (2 * FRAME) cyc();
        for (k = 0; k < 2 * FRAME && !(px(n) == 10 && py(n) == 8); k++) cyc();
        rst = 1'b1;
        cyc();
        chk("rst_mid_x", 32'(bus.pix_x), 0);
        chk("rst_mid_y", 32'(bus.pix_y), 0);
        chk("rst_mid_rgb", 32'({bus.vid_red, bus.vid_green, bus.vid_blue}), 0);
        chk("rst_mid_nmi", 32'(bus.host_nmi), 0);
        rst = 1'b0;
        host(3'd6, 1, 0, 8'h00);
        repeat (4) host(3'd7, 0, 1, 8'h00);
        repeat (FRAME) cyc();
        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
